// File: rtl/key_stream_loader.sv
// Serial key loader: shifts in key + XOR-fold checksum LSB first, verifies it, then
// applies the key to the parallel keyinput bus in one step and holds it for a settle window.
module key_stream_loader #(
  parameter int KEY_W      = 16,
  parameter int CHK_W      = 4,
  parameter int SETTLE_CYC = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             key_clear,
  input  logic             ser_valid,
  input  logic             ser_data,
  output logic             ser_ready,
  output logic [KEY_W-1:0] key_out,
  output logic             key_valid,
  output logic             busy,
  output logic             err
);

  localparam int TOT_W = KEY_W + CHK_W;
  localparam int CNT_W = $clog2(TOT_W + 1);
  localparam int SET_W = $clog2(SETTLE_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SHIFT = 3'd1,
    S_CHECK = 3'd2,
    S_APPLY = 3'd3,
    S_HOLD  = 3'd4,
    S_ERROR = 3'd5
  } state_t;

  function automatic logic [CHK_W-1:0] xor_fold(input logic [KEY_W-1:0] k);
    logic [CHK_W-1:0] f;
    f = '0;
    for (int i = 0; i < KEY_W / CHK_W; i++) begin
      f = f ^ k[i*CHK_W +: CHK_W];
    end
    return f;
  endfunction

  state_t           state_q, state_d;
  logic [TOT_W-1:0] sr_q, sr_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [SET_W-1:0] set_cnt_q, set_cnt_d;
  logic [KEY_W-1:0] key_out_q, key_out_d;
  logic             ser_ready_q, ser_ready_d;
  logic             key_valid_q, key_valid_d;
  logic             busy_q, busy_d;
  logic             err_q, err_d;

  // Next-state and datapath computation; outputs are derived from the next state so they register cleanly.
  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    bit_cnt_d = bit_cnt_q;
    set_cnt_d = set_cnt_q;
    key_out_d = key_out_q;
    err_d     = err_q;
    if (key_clear) begin
      state_d   = S_IDLE;
      sr_d      = '0;
      bit_cnt_d = '0;
      set_cnt_d = '0;
      key_out_d = '0;
      err_d     = 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_HOLD, S_ERROR: begin
          if (start) begin
            state_d   = S_SHIFT;
            bit_cnt_d = '0;
            set_cnt_d = '0;
            err_d     = 1'b0;
          end else begin
            state_d = state_q;
          end
        end
        S_SHIFT: begin
          // Full frame sits one cycle with ser_ready low before CHECK; no extra bits are taken.
          if (bit_cnt_q == CNT_W'(TOT_W)) begin
            state_d = S_CHECK;
          end else if (ser_valid && ser_ready_q) begin
            sr_d      = {ser_data, sr_q[TOT_W-1:1]};
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end else begin
            state_d = S_SHIFT;
          end
        end
        S_CHECK: begin
          if (xor_fold(sr_q[KEY_W-1:0]) == sr_q[TOT_W-1:KEY_W]) begin
            state_d   = S_APPLY;
            key_out_d = sr_q[KEY_W-1:0];
            set_cnt_d = '0;
          end else begin
            state_d = S_ERROR;
            err_d   = 1'b1;
          end
        end
        S_APPLY: begin
          if (set_cnt_q == SET_W'(SETTLE_CYC - 1)) begin
            state_d = S_HOLD;
          end else begin
            set_cnt_d = set_cnt_q + SET_W'(1);
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
    ser_ready_d = (state_d == S_SHIFT) && (bit_cnt_d != CNT_W'(TOT_W));
    busy_d      = (state_d == S_SHIFT) || (state_d == S_CHECK) || (state_d == S_APPLY);
    key_valid_d = (state_d == S_HOLD);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      sr_q        <= '0;
      bit_cnt_q   <= '0;
      set_cnt_q   <= '0;
      key_out_q   <= '0;
      ser_ready_q <= 1'b0;
      key_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      bit_cnt_q   <= bit_cnt_d;
      set_cnt_q   <= set_cnt_d;
      key_out_q   <= key_out_d;
      ser_ready_q <= ser_ready_d;
      key_valid_q <= key_valid_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
    end
  end

  assign ser_ready = ser_ready_q;
  assign key_out   = key_out_q;
  assign key_valid = key_valid_q;
  assign busy      = busy_q;
  assign err       = err_q;

endmodule
